// File: rtl/lfsr_rng.sv
// lfsr_rng: XNOR-feedback LFSR with a rejection-sampling draw FSM returning values in 0..RANGE-1
module lfsr_rng #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
  parameter int               OUT_W     = 4,
  parameter int               RANGE     = 9,
  parameter int               MAX_TRIES = 8,
  parameter int               NO_REPEAT = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  input  logic             ack,
  output logic             ready,
  output logic             valid,
  output logic [OUT_W-1:0] value,
  output logic             fallback,
  output logic [WIDTH-1:0] state
);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam logic [OUT_W:0] LIM = (OUT_W + 1)'(RANGE);
  typedef enum logic [1:0] {IDLE, DRAW, DONE} st_t;
  st_t st, st_nx;
  logic [TW-1:0] tries;
  logic has_prev;
  logic [OUT_W-1:0] cand;
  logic fb, rep, rej, last;
  assign fb = ~^(state & TAPS);
  assign cand = state[OUT_W-1:0];
  assign rep = (NO_REPEAT != 0) && (RANGE > 1) && has_prev && (cand == value);
  assign rej = ({1'b0, cand} >= LIM) || rep;
  assign last = tries == TW'(MAX_TRIES - 1);
  assign ready = st == IDLE;
  assign valid = st == DONE;
  // FSM state register
  always_ff @(posedge clock or posedge reset)
    if (reset) st <= IDLE;
    else st <= st_nx;
  // next-state: idle waits for req, draw ends on accept or exhausted tries, done waits for ack
  always_comb begin
    st_nx = st;
    case (st)
      IDLE: st_nx = req ? DRAW : IDLE;
      DRAW: st_nx = (!rej || last) ? DONE : DRAW;
      DONE: st_nx = ack ? IDLE : DONE;
      default: st_nx = IDLE;
    endcase
  end
  // LFSR: seed load wins, then advance on free-run or while drawing; all-ones seed maps to zero
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= '0;
    else if (seed_load) state <= (&seed) ? '0 : seed;
    else if (enable || st == DRAW) state <= {state[WIDTH-2:0], fb};
  // draw datapath: try counter, captured value, fallback flag and repeat-tracking flag
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      tries    <= '0;
      value    <= '0;
      fallback <= 1'b0;
      has_prev <= 1'b0;
    end else begin
      if (st == IDLE && req) tries <= '0;
      if (st == DRAW) begin
        if (!rej) begin
          value    <= cand;
          fallback <= 1'b0;
        end else if (last) begin
          value    <= '0;
          fallback <= 1'b1;
        end else tries <= tries + TW'(1);
      end
      if (st == DONE && ack) has_prev <= 1'b1;
    end
endmodule
